// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the EX/MEM stage and the byte-addressed data memory.
// The pipeline side drives the request fields; the memory answers with a one-cycle ready pulse.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              misalign;
    logic              busy;

    modport master (
        output req, we, size, unsigned_ld, addr, wdata,
        input  rdata, ready, misalign, busy
    );

    modport slave (
        input  req, we, size, unsigned_ld, addr, wdata,
        output rdata, ready, misalign, busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with req/ready handshake, programmable wait states,
// byte/half/word lane-enabled stores, sign/zero-extended loads and misalignment flagging.
module data_mem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic          CLK,
    input  logic          reset,
    data_mem_ctrl_if.slave bus
);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [1:0]        size_r;
    logic              uns_r;
    logic [IDX_W+1:0]  addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              ready_r;
    logic              misalign_r;
    logic              busy_r;
    logic [31:0]       mem_r [DEPTH];

    logic [IDX_W-1:0]  idx_s;
    logic [1:0]        lane_s;
    logic              bad_s;
    logic [3:0]        be_s;
    logic [31:0]       wword_s;
    logic [31:0]       word_s;
    logic [31:0]       load_s;
    logic              accept_s;
    logic              access_s;
    logic              unused_addr_s;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        logic bad;
        case (sz)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001 << lane;
            2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic uns,
                                                input logic [1:0] lane, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (sz)
            2'b00:   r = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            2'b10:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Decode the latched request into word index, lane enables and load result.
    always_comb begin
        idx_s    = addr_r[IDX_W+1:2];
        lane_s   = addr_r[1:0];
        bad_s    = is_misaligned(size_r, lane_s);
        be_s     = lane_mask(size_r, lane_s);
        wword_s  = replicate(size_r, wdata_r);
        word_s   = mem_r[idx_s];
        load_s   = load_extend(size_r, uns_r, lane_s, word_s);
        accept_s = bus.req && ((state_r == ST_IDLE) || (state_r == ST_RESP));
        // WAIT lasts LATENCY+1 cycles; the access fires on its final edge.
        access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    end

    assign unused_addr_s = ^bus.addr[ADDR_W-1:IDX_W+2];

    // Commit legal stores on the edge that enters the response cycle.
    always_ff @(posedge CLK) begin
        if (!reset && access_s && we_r && !bad_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wword_s[8*b +: 8];
                end
            end
        end
    end

    // Handshake FSM: accept, count wait states, then present one response cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            uns_r      <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
            ready_r    <= 1'b0;
            misalign_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    // The edge leaving RESP may already take the next request.
                    if (accept_s) begin
                        we_r    <= bus.we;
                        size_r  <= bus.size;
                        uns_r   <= bus.unsigned_ld;
                        addr_r  <= bus.addr[IDX_W+1:0];
                        wdata_r <= bus.wdata;
                        cnt_r   <= LAT_C;
                        busy_r  <= 1'b1;
                        state_r <= ST_WAIT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r    <= ST_RESP;
                        ready_r    <= 1'b1;
                        misalign_r <= bad_s;
                        rdata_r    <= (bad_s || we_r) ? 32'h0000_0000 : load_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata    = rdata_r;
    assign bus.ready    = ready_r;
    assign bus.misalign = misalign_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (LATENCY 1, 0, 3) checked every cycle
// against a byte-array memory model plus hand-computed expectations.
module tb_data_mem_ctrl;
    logic        clk;
    logic [2:0]  rst_v;
    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [2:0]  uns_v;
    logic [1:0]  size_v  [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [31:0] rdata_w [3];
    logic [2:0]  ready_w;
    logic [2:0]  mis_w;
    logic [2:0]  busy_w;

    int vec;
    int err;
    logic chk_en;

    // Model state
    logic [7:0]  mm [3][256];
    int          left [3];
    logic [2:0]  acc_f;
    logic [2:0]  rst_f;
    logic        op_we   [3];
    logic        op_uns  [3];
    logic [1:0]  op_size [3];
    logic [31:0] op_addr [3];
    logic [31:0] op_wdata[3];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        data_mem_ctrl_if #(.ADDR_W(32)) bus ();
        data_mem_ctrl #(.DEPTH(64), .LATENCY(LAT), .ADDR_W(32)) dut (
            .CLK  (clk),
            .reset(rst_v[g]),
            .bus  (bus)
        );
        assign bus.req         = req_v[g];
        assign bus.we          = we_v[g];
        assign bus.size        = size_v[g];
        assign bus.unsigned_ld = uns_v[g];
        assign bus.addr        = addr_v[g];
        assign bus.wdata       = wdata_v[g];
        assign rdata_w[g]      = bus.rdata;
        assign ready_w[g]      = bus.ready;
        assign mis_w[g]        = bus.misalign;
        assign busy_w[g]       = bus.busy;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vec++;
        if (act !== want) begin
            err++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    // Performs the pending access of instance g on the byte model.
    task automatic model_apply(input int g, output logic [31:0] rd, output logic mis);
        int          nb;
        int          base;
        logic [31:0] v;
        mis = (op_size[g] == 2'd3) || (op_size[g] == 2'd1 && op_addr[g][0]) ||
              (op_size[g] == 2'd2 && op_addr[g][1:0] != 2'd0);
        rd = 32'h0;
        if (!mis) begin
            nb   = 1 << op_size[g];
            base = int'(op_addr[g][7:0]);
            if (op_we[g]) begin
                for (int i = 0; i < nb; i++) mm[g][base + i] = op_wdata[g][8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[g][base + i];
                if (nb == 1)      rd = op_uns[g] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                else if (nb == 2) rd = op_uns[g] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else              rd = v;
            end
        end
    endtask

    // Record what each instance must have seen at this rising edge.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            rst_f[g] <= rst_v[g];
            acc_f[g] <= req_v[g] && !rst_v[g] && (left[g] == 0);
            if (req_v[g] && !rst_v[g] && (left[g] == 0)) begin
                op_we[g]    <= we_v[g];
                op_uns[g]   <= uns_v[g];
                op_size[g]  <= size_v[g];
                op_addr[g]  <= addr_v[g];
                op_wdata[g] <= wdata_v[g];
            end
        end
    end

    // Compare every instance against the model once per cycle.
    always @(negedge clk) begin
        int          l;
        logic [31:0] rd;
        logic        mis;
        for (int g = 0; g < 3; g++) begin
            l = left[g];
            if (rst_f[g])      l = 0;
            else if (acc_f[g]) l = lat_of(g) + 2;
            if (l == 1) model_apply(g, rd, mis);
            if (chk_en) begin
                chk($sformatf("dut%0d busy", g), {31'b0, busy_w[g]}, {31'b0, l > 0});
                chk($sformatf("dut%0d ready", g), {31'b0, ready_w[g]}, {31'b0, l == 1});
                if (l == 1) begin
                    chk($sformatf("dut%0d model rdata", g), rdata_w[g], rd);
                    chk($sformatf("dut%0d model misalign", g), {31'b0, mis_w[g]}, {31'b0, mis});
                end
            end
            left[g] <= (l > 0) ? l - 1 : 0;
        end
    end

    task automatic access(input int g, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] want_rd, input logic want_mis, input string nm);
        int n;
        @(negedge clk);
        req_v[g] = 1'b1; we_v[g] = w; size_v[g] = sz; uns_v[g] = u;
        addr_v[g] = a; wdata_v[g] = d;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req_v[g] = 1'b0; we_v[g] = ~w; size_v[g] = ~sz;
                addr_v[g] = ~a; wdata_v[g] = ~d;
            end
        end while (!ready_w[g] && n < 20);
        chk({nm, " latency"}, 32'(n), 32'(lat_of(g) + 2));
        chk({nm, " rdata"}, rdata_w[g], want_rd);
        chk({nm, " misalign"}, {31'b0, mis_w[g]}, {31'b0, want_mis});
    endtask

    task automatic expect_idle(input int g, input string nm);
        chk({nm, " ready"}, {31'b0, ready_w[g]}, 32'h0);
        chk({nm, " busy"}, {31'b0, busy_w[g]}, 32'h0);
        chk({nm, " misalign"}, {31'b0, mis_w[g]}, 32'h0);
    endtask

    initial begin
        int cnt;
        vec = 0; err = 0; chk_en = 1'b0;
        for (int g = 0; g < 3; g++) begin
            left[g] = 0; size_v[g] = 2'b10; addr_v[g] = 32'h0; wdata_v[g] = 32'h0;
        end
        rst_v = 3'b111; req_v = 3'b000; we_v = 3'b000; uns_v = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            expect_idle(g, $sformatf("reset dut%0d", g));
            chk($sformatf("reset dut%0d rdata", g), rdata_w[g], 32'h0);
        end
        rst_v = 3'b000;
        chk_en = 1'b1;

        // LATENCY=1 instance
        access(0, 1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, "sw 10");
        access(0, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, "lw 10");
        access(0, 1'b1, 2'b10, 1'b0, 32'h10,  32'h11223344, 32'h0,        1'b0, "sw 10b");
        access(0, 1'b1, 2'b00, 1'b0, 32'h13,  32'h00000080, 32'h0,        1'b0, "sb 13");
        access(0, 1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, "lb 13");
        access(0, 1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'h00000080, 1'b0, "lbu 13");
        access(0, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h80223344, 1'b0, "lw 10b");
        access(0, 1'b1, 2'b10, 1'b0, 32'h20,  32'h0,        32'h0,        1'b0, "sw 20");
        access(0, 1'b1, 2'b01, 1'b0, 32'h22,  32'h0000A5A5, 32'h0,        1'b0, "sh 22");
        access(0, 1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'hFFFFA5A5, 1'b0, "lh 22");
        access(0, 1'b0, 2'b01, 1'b1, 32'h20,  32'h0,        32'h00000000, 1'b0, "lhu 20");
        access(0, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hA5A50000, 1'b0, "lw 20");
        access(0, 1'b1, 2'b10, 1'b0, 32'h04,  32'h55667788, 32'h0,        1'b0, "sw 04");
        access(0, 1'b1, 2'b10, 1'b0, 32'h05,  32'h99999999, 32'h0,        1'b1, "sw 05 mis");
        access(0, 1'b0, 2'b01, 1'b0, 32'h07,  32'h0,        32'h0,        1'b1, "lh 07 mis");
        access(0, 1'b0, 2'b11, 1'b0, 32'h00,  32'h0,        32'h0,        1'b1, "size3 ld");
        access(0, 1'b1, 2'b11, 1'b0, 32'h04,  32'hFFFFFFFF, 32'h0,        1'b1, "size3 st");
        access(0, 1'b0, 2'b10, 1'b0, 32'h04,  32'h0,        32'h55667788, 1'b0, "lw 04");
        access(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 32'h0,        1'b0, "sw 100");
        access(0, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0, "lw 000 wrap");

        // Reset and req on the same edge: request dropped
        @(negedge clk);
        rst_v[0] = 1'b1; req_v[0] = 1'b1; we_v[0] = 1'b1; size_v[0] = 2'b10; addr_v[0] = 32'h0;
        @(negedge clk);
        rst_v[0] = 1'b0; req_v[0] = 1'b0;
        expect_idle(0, "rst+req");
        @(negedge clk);
        chk("rst+req later busy", {31'b0, busy_w[0]}, 32'h0);

        // LATENCY=0 instance
        access(1, 1'b1, 2'b10, 1'b0, 32'h0, 32'hA1B2C3D4, 32'h0,        1'b0, "l0 sw 0");
        access(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'hA1B2C3D4, 1'b0, "l0 lw 0");
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b0; size_v[1] = 2'b10; addr_v[1] = 32'h0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready_w[1]) cnt++;
        end
        req_v[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready_w[1]) cnt++;
        end
        chk("l0 back-to-back responses", 32'(cnt), 32'd4);

        // LATENCY=3 instance: reset during WAIT aborts the store
        access(2, 1'b1, 2'b10, 1'b0, 32'h08, 32'h01020304, 32'h0, 1'b0, "l3 sw 08");
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; size_v[2] = 2'b10; addr_v[2] = 32'h08; wdata_v[2] = 32'hCAFEF00D;
        @(negedge clk);
        req_v[2] = 1'b0;
        @(negedge clk);
        rst_v[2] = 1'b1;
        @(negedge clk);
        expect_idle(2, "mid-op reset");
        rst_v[2] = 1'b0;
        repeat (8) @(negedge clk);
        access(2, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h01020304, 1'b0, "l3 lw 08");

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
